osc_bank_anasymod: RTL and testbench

OSC_BANK_ANASYMOD -- requirements
Module: osc_bank_anasymod

---
 rtl/osc_bank_anasymod_if.sv | 31 +++
 rtl/osc_bank_anasymod.sv | 82 ++++++++
 tb/tb_osc_bank_anasymod.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/osc_bank_anasymod_if.sv
// osc_bank_anasymod_if: timestep negotiation and per-channel control/status bundle for the oscillator bank.
//   __emu_dt     : timestep applied this cycle (environment -> bank)
//   __emu_dt_req : timestep requested by the bank (bank -> environment)
//   en           : per-channel run enable
//   t_lo, t_hi   : per-channel low/high phase durations, channel i at [i*DT_WIDTH +: DT_WIDTH]
//   clk_val, cke : per-channel level and edge strobe
//   err          : sticky timestep-overrun flag
`ifndef DT_WIDTH
`define DT_WIDTH 32
`endif
interface osc_bank_anasymod_if #(
    parameter int N_CH     = 4,
    parameter int DT_WIDTH = `DT_WIDTH
);
    logic [DT_WIDTH-1:0]      __emu_dt;
    logic [DT_WIDTH-1:0]      __emu_dt_req;
    logic [N_CH-1:0]          en;
    logic [N_CH*DT_WIDTH-1:0] t_lo;
    logic [N_CH*DT_WIDTH-1:0] t_hi;
    logic [N_CH-1:0]          clk_val;
    logic [N_CH-1:0]          cke;
    logic                     err;
    modport master (
        output __emu_dt, en, t_lo, t_hi,
        input  __emu_dt_req, clk_val, cke, err
    );
    modport slave (
        input  __emu_dt, en, t_lo, t_hi,
        output __emu_dt_req, clk_val, cke, err
    );
endinterface

// File: rtl/osc_bank_anasymod.sv
// osc_bank_anasymod: bank of N_CH event-driven square-wave oscillators with timestep request/overrun tracking.
//   __emu_clk   : emulator clock, all state on its rising edge
//   __emu_rst_n : asynchronous active-low reset
//   bus         : osc_bank_anasymod_if slave (dt/dt_req, en, t_lo/t_hi, clk_val, cke, err)
`ifndef DT_WIDTH
`define DT_WIDTH 32
`endif
module osc_bank_anasymod #(
    parameter int N_CH     = 4,
    parameter int DT_WIDTH = `DT_WIDTH
) (
    input logic               __emu_clk,
    input logic               __emu_rst_n,
    osc_bank_anasymod_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t [N_CH-1:0]                state, state_nxt;
    logic   [N_CH-1:0][DT_WIDTH-1:0]  rem, rem_nxt;
    logic   [N_CH-1:0]                lvl, lvl_nxt;
    logic   [N_CH-1:0]                cke_c;
    logic   [DT_WIDTH-1:0]            req;
    logic                             err_q, err_nxt;

    // zero durations would stall time; treat them as the smallest step
    function automatic logic [DT_WIDTH-1:0] clamp1(input logic [DT_WIDTH-1:0] d);
        return (d == '0) ? DT_WIDTH'(1) : d;
    endfunction

    always_ff @(posedge __emu_clk or negedge __emu_rst_n) begin
        if (!__emu_rst_n) begin
            state <= {N_CH{IDLE}};
            rem   <= '0;
            lvl   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            lvl   <= lvl_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        lvl_nxt   = lvl;
        err_nxt   = err_q;
        cke_c     = '0;
        req       = '1;
        for (int i = 0; i < N_CH; i++) begin
            if (state[i] == IDLE) begin
                if (bus.en[i]) begin
                    state_nxt[i] = RUN;
                    rem_nxt[i]   = clamp1(bus.t_lo[i*DT_WIDTH +: DT_WIDTH]);
                    lvl_nxt[i]   = 1'b0;
                end
            end else if (!bus.en[i]) begin
                // disable wins over an edge falling in the same cycle
                state_nxt[i] = IDLE;
                rem_nxt[i]   = '0;
                lvl_nxt[i]   = 1'b0;
            end else if (bus.__emu_dt >= rem[i]) begin
                // edge: excess time beyond rem is dropped, only flagged
                cke_c[i]   = 1'b1;
                lvl_nxt[i] = ~lvl[i];
                rem_nxt[i] = lvl[i] ? clamp1(bus.t_lo[i*DT_WIDTH +: DT_WIDTH])
                                    : clamp1(bus.t_hi[i*DT_WIDTH +: DT_WIDTH]);
                err_nxt    = err_nxt | (bus.__emu_dt > rem[i]);
            end else begin
                rem_nxt[i] = rem[i] - bus.__emu_dt;
            end
            if (state[i] == RUN && rem[i] < req)
                req = rem[i];
        end
    end

    assign bus.__emu_dt_req = req;
    assign bus.clk_val      = lvl;
    assign bus.cke          = cke_c;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_osc_bank_anasymod.sv
// tb_osc_bank_anasymod: directed self-checking bench for osc_bank_anasymod (two channels).
module tb_osc_bank_anasymod;
    localparam int N  = 2;
    localparam int DW = 32;
    localparam logic [31:0] ONES = 32'hffff_ffff;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;

    osc_bank_anasymod_if #(.N_CH(N), .DT_WIDTH(DW)) bus ();

    osc_bank_anasymod #(.N_CH(N), .DT_WIDTH(DW)) dut (
        .__emu_clk   (clk),
        .__emu_rst_n (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int r3 [4] = '{4, 2, 2, 4};
    int c3 [4] = '{1, 2, 1, 3};
    int l3 [4] = '{0, 1, 3, 2};

    initial begin
        rst_n = 1'b0;
        bus.en = '0;
        bus.t_lo = '0;
        bus.t_hi = '0;
        bus.__emu_dt = 32'd1;
        #3;
        chk("rst_dt_req", bus.__emu_dt_req, ONES);
        chk("rst_clk_val", 32'(bus.clk_val), 0);
        chk("rst_cke", 32'(bus.cke), 0);
        chk("rst_err", 32'(bus.err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // single channel 3/5, dt follows dt_req
        bus.t_lo = {32'd0, 32'd3};
        bus.t_hi = {32'd0, 32'd5};
        bus.en = 2'b01;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk("alt_dt_req", bus.__emu_dt_req, (k % 2) ? 32'd5 : 32'd3);
            chk("alt_clk_val", 32'(bus.clk_val), 32'(k % 2));
            bus.__emu_dt = bus.__emu_dt_req;
            #1;
            chk("alt_cke", 32'(bus.cke), 1);
            tick();
        end
        chk("alt_err", 32'(bus.err), 0);
        // two channels 4/4 and 6/6
        bus.en = 2'b00;
        tick();
        chk("idle_dt_req", bus.__emu_dt_req, ONES);
        bus.t_lo = {32'd6, 32'd4};
        bus.t_hi = {32'd6, 32'd4};
        bus.en = 2'b11;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("dual_dt_req", bus.__emu_dt_req, 32'(r3[k]));
            chk("dual_clk_val", 32'(bus.clk_val), 32'(l3[k]));
            bus.__emu_dt = bus.__emu_dt_req;
            #1;
            chk("dual_cke", 32'(bus.cke), 32'(c3[k]));
            tick();
        end
        chk("dual_clk_end", 32'(bus.clk_val), 1);
        chk("dual_err", 32'(bus.err), 0);
        // zero durations clamp to 1
        bus.en = 2'b00;
        tick();
        bus.t_lo = '0;
        bus.t_hi = '0;
        bus.en = 2'b01;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("zero_dt_req", bus.__emu_dt_req, 1);
            chk("zero_clk_val", 32'(bus.clk_val), 32'(k % 2));
            bus.__emu_dt = bus.__emu_dt_req;
            tick();
        end
        // overrun
        bus.en = 2'b00;
        tick();
        bus.t_lo = {32'd0, 32'd10};
        bus.t_hi = {32'd0, 32'd8};
        bus.en = 2'b01;
        tick();
        chk("ovr_dt_req0", bus.__emu_dt_req, 10);
        bus.__emu_dt = 32'd4;
        #1;
        chk("ovr_cke0", 32'(bus.cke), 0);
        tick();
        chk("ovr_dt_req1", bus.__emu_dt_req, 6);
        bus.__emu_dt = 32'd7;
        #1;
        chk("ovr_cke1", 32'(bus.cke), 1);
        chk("ovr_err_pre", 32'(bus.err), 0);
        tick();
        chk("ovr_err", 32'(bus.err), 1);
        chk("ovr_clk_val", 32'(bus.clk_val), 1);
        chk("ovr_dt_req2", bus.__emu_dt_req, 8);
        bus.__emu_dt = 32'd1;
        tick();
        chk("ovr_dt_req3", bus.__emu_dt_req, 7);
        bus.en = 2'b00;
        tick();
        tick();
        chk("ovr_err_sticky", 32'(bus.err), 1);
        chk("ovr_idle_req", bus.__emu_dt_req, ONES);
        // disable coinciding with an edge
        bus.t_lo = {32'd0, 32'd2};
        bus.en = 2'b01;
        tick();
        chk("dis_dt_req", bus.__emu_dt_req, 2);
        bus.en = 2'b00;
        bus.__emu_dt = 32'd2;
        #1;
        chk("dis_cke", 32'(bus.cke), 0);
        tick();
        chk("dis_clk_val", 32'(bus.clk_val), 0);
        chk("dis_dt_req_idle", bus.__emu_dt_req, ONES);
        // asynchronous reset mid-run
        bus.t_lo = {32'd0, 32'd3};
        bus.t_hi = {32'd0, 32'd5};
        bus.en = 2'b01;
        tick();
        bus.__emu_dt = 32'd3;
        tick();
        chk("ar_pre_clk_val", 32'(bus.clk_val), 1);
        chk("ar_pre_dt_req", bus.__emu_dt_req, 5);
        rst_n = 1'b0;
        #1;
        chk("ar_clk_val", 32'(bus.clk_val), 0);
        chk("ar_dt_req", bus.__emu_dt_req, ONES);
        chk("ar_cke", 32'(bus.cke), 0);
        chk("ar_err", 32'(bus.err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ar_restart_req", bus.__emu_dt_req, 3);
        chk("ar_restart_clk", 32'(bus.clk_val), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
